// File: rtl/aes_iter_core_if.sv
// Handshake and data bus of the iterative AES core: input offer, result return,
// and the externally held expanded key schedule.
interface aes_iter_core_if #(
  parameter int KW = 1920
) ();
  logic          in_valid;
  logic          in_ready;
  logic          decrypt;
  logic [127:0]  data_in;
  logic [KW-1:0] key_in;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  data_out;
  logic          busy;

  modport master (
    output in_valid, decrypt, data_in, key_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, decrypt, data_in, key_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/aes_iter_core.sv
// Iterative AES encrypt/decrypt core: one round per clock, IDLE/ROUND/DONE control,
// round keys read directly from the caller's expanded key bus.
module aes_iter_core #(
  parameter int NR = 14,
  parameter int KW = 128*(NR+1)
) (
  input  logic          clk,
  input  logic          rst,
  aes_iter_core_if.slave bus
);
  localparam int RCW = $clog2(NR+1);

  generate
    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
      $error("aes_iter_core: NR must be 10, 12 or 14");
    end
    if (KW != 128*(NR+1)) begin : g_bad_kw
      $error("aes_iter_core: KW must equal 128*(NR+1)");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t         state_reg, state_next;
  logic [RCW-1:0] round_cnt_reg, round_cnt_next;
  logic           mode_reg, mode_next;
  logic [127:0]   aes_state_reg, aes_state_next;
  logic [127:0]   data_out_reg, data_out_next;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, sq);
      sq = gmul(sq, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = ginv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  logic [127:0] sr_enc, mix_enc, isb_dec, dec_ark, imix_dec;
  logic [127:0] rk_first, rk_last, rk_enc, rk_dec;
  logic [RCW-1:0] dec_idx;

  assign dec_idx  = RCW'(NR) - round_cnt_reg;
  assign rk_first = bus.key_in[127:0];
  assign rk_last  = bus.key_in[128*NR +: 128];
  assign rk_enc   = bus.key_in[128*int'(round_cnt_reg) +: 128];
  assign rk_dec   = bus.key_in[128*int'(dec_idx) +: 128];
  assign dec_ark  = isb_dec ^ rk_dec;

  // Byte gi sits at row gi%4, column gi/4; (Inv)ShiftRows folds into the S-box source index.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bytes
      localparam int R    = gi % 4;
      localparam int C    = gi / 4;
      localparam int ESRC = 4*((C + R) % 4) + R;
      localparam int DSRC = 4*((C + 4 - R) % 4) + R;
      assign sr_enc[127-8*gi -: 8]  = sbox(aes_state_reg[127-8*ESRC -: 8]);
      assign isb_dec[127-8*gi -: 8] = inv_sbox(aes_state_reg[127-8*DSRC -: 8]);
    end

    for (gi = 0; gi < 4; gi++) begin : g_cols
      logic [7:0] e0, e1, e2, e3, d0, d1, d2, d3;
      assign {e0, e1, e2, e3} = sr_enc[127-32*gi -: 32];
      assign {d0, d1, d2, d3} = dec_ark[127-32*gi -: 32];
      assign mix_enc[127-32*gi -: 32] = {
        gmul(e0, 8'h02) ^ gmul(e1, 8'h03) ^ e2 ^ e3,
        e0 ^ gmul(e1, 8'h02) ^ gmul(e2, 8'h03) ^ e3,
        e0 ^ e1 ^ gmul(e2, 8'h02) ^ gmul(e3, 8'h03),
        gmul(e0, 8'h03) ^ e1 ^ e2 ^ gmul(e3, 8'h02)};
      assign imix_dec[127-32*gi -: 32] = {
        gmul(d0, 8'h0e) ^ gmul(d1, 8'h0b) ^ gmul(d2, 8'h0d) ^ gmul(d3, 8'h09),
        gmul(d0, 8'h09) ^ gmul(d1, 8'h0e) ^ gmul(d2, 8'h0b) ^ gmul(d3, 8'h0d),
        gmul(d0, 8'h0d) ^ gmul(d1, 8'h09) ^ gmul(d2, 8'h0e) ^ gmul(d3, 8'h0b),
        gmul(d0, 8'h0b) ^ gmul(d1, 8'h0d) ^ gmul(d2, 8'h09) ^ gmul(d3, 8'h0e)};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      round_cnt_reg <= '0;
      mode_reg      <= 1'b0;
      aes_state_reg <= '0;
      data_out_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      round_cnt_reg <= round_cnt_next;
      mode_reg      <= mode_next;
      aes_state_reg <= aes_state_next;
      data_out_reg  <= data_out_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    round_cnt_next = round_cnt_reg;
    mode_next      = mode_reg;
    aes_state_next = aes_state_reg;
    data_out_next  = data_out_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          mode_next      = bus.decrypt;
          aes_state_next = bus.data_in ^ (bus.decrypt ? rk_last : rk_first);
          round_cnt_next = RCW'(1);
          state_next     = ROUND;
        end
      end
      ROUND: begin
        if (round_cnt_reg == RCW'(NR)) begin
          data_out_next = mode_reg ? (isb_dec ^ rk_first) : (sr_enc ^ rk_last);
          state_next    = DONE;
        end else begin
          aes_state_next = mode_reg ? imix_dec : (mix_enc ^ rk_enc);
          round_cnt_next = round_cnt_reg + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.data_out  = data_out_reg;
endmodule

// File: tb/tb_aes_iter_core.sv
// Directed and model-checked bench for aes_iter_core at NR=10, 12 and 14,
// sharing one stimulus port that is steered to the selected core.
module tb_aes_iter_core;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_iter_core_if #(.KW(1408)) if10 ();
  aes_iter_core_if #(.KW(1664)) if12 ();
  aes_iter_core_if #(.KW(1920)) if14 ();

  aes_iter_core #(.NR(10)) u_dut10 (.clk(clk), .rst(rst), .bus(if10));
  aes_iter_core #(.NR(12)) u_dut12 (.clk(clk), .rst(rst), .bus(if12));
  aes_iter_core #(.NR(14)) u_dut14 (.clk(clk), .rst(rst), .bus(if14));

  logic         in_valid, decrypt, out_ready;
  logic [127:0] data_in;
  int           sel;
  logic [1919:0] rk10, rk12, rk14;

  assign if10.in_valid  = in_valid && (sel == 10);
  assign if10.out_ready = out_ready && (sel == 10);
  assign if10.decrypt   = decrypt;
  assign if10.data_in   = data_in;
  assign if10.key_in    = rk10[1407:0];
  assign if12.in_valid  = in_valid && (sel == 12);
  assign if12.out_ready = out_ready && (sel == 12);
  assign if12.decrypt   = decrypt;
  assign if12.data_in   = data_in;
  assign if12.key_in    = rk12[1663:0];
  assign if14.in_valid  = in_valid && (sel == 14);
  assign if14.out_ready = out_ready && (sel == 14);
  assign if14.decrypt   = decrypt;
  assign if14.data_in   = data_in;
  assign if14.key_in    = rk14;

  logic         o_rdy, o_ov, o_busy;
  logic [127:0] o_dout;
  always_comb begin
    o_rdy = if10.in_ready; o_ov = if10.out_valid; o_busy = if10.busy; o_dout = if10.data_out;
    if (sel == 12) begin
      o_rdy = if12.in_ready; o_ov = if12.out_valid; o_busy = if12.busy; o_dout = if12.data_out;
    end else if (sel == 14) begin
      o_rdy = if14.in_ready; o_ov = if14.out_valid; o_busy = if14.busy; o_dout = if14.data_out;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input int n);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 4; i++) begin
      if (n[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  // Classic generator walk: p steps through powers of 3, q through powers of 1/3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
  endtask

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [1919:0] rkv;
    int nk;
    nk  = nr - 6;
    rc  = 8'h01;
    rkv = '0;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = {t[23:0], t[31:24]};
          t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) rkv[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rkv;
  endfunction

  function automatic logic [127:0] m_subshift(input logic [127:0] s, input bit inv);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!inv) t[127-8*(4*c+r) -: 8] = sbox_t[s[127-8*(4*((c+r)%4)+r) -: 8]];
        else      t[127-8*(4*((c+r)%4)+r) -: 8] = isbox_t[s[127-8*(4*c+r) -: 8]];
    return t;
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] s, input bit inv);
    logic [127:0] t;
    logic [7:0] a [4];
    t = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        if (!inv) t[127-8*(4*c+r) -: 8] = gm(a[r], 2) ^ gm(a[(r+1)%4], 3) ^ a[(r+2)%4] ^ a[(r+3)%4];
        else      t[127-8*(4*c+r) -: 8] = gm(a[r], 14) ^ gm(a[(r+1)%4], 11) ^ gm(a[(r+2)%4], 13) ^ gm(a[(r+3)%4], 9);
    end
    return t;
  endfunction

  function automatic logic [127:0] m_enc(input logic [127:0] pt, input logic [1919:0] rk, input int nr);
    logic [127:0] s;
    s = pt ^ rk[127:0];
    for (int r = 1; r < nr; r++) s = m_mix(m_subshift(s, 0), 0) ^ rk[128*r +: 128];
    return m_subshift(s, 0) ^ rk[128*nr +: 128];
  endfunction

  function automatic logic [127:0] m_dec(input logic [127:0] ct, input logic [1919:0] rk, input int nr);
    logic [127:0] s;
    s = ct ^ rk[128*nr +: 128];
    for (int r = 1; r < nr; r++) s = m_mix(m_subshift(s, 1) ^ rk[128*(nr-r) +: 128], 1);
    return m_subshift(s, 1) ^ rk[127:0];
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int s, input logic dec, input logic [127:0] din, output int acc_cyc);
    int n;
    sel = s; decrypt = dec; data_in = din; in_valid = 1'b1;
    n = 0;
    while (!o_rdy && n < 50) begin step(); n++; end
    if (!o_rdy) chk("accept_timeout", 128'(o_rdy), 128'(1));
    step();
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit toggle, output int lat, output logic [127:0] dout);
    lat = 0;
    while (!o_ov && lat < 40) begin
      if (toggle) begin decrypt = ~decrypt; in_valid = ~in_valid; end
      step();
      lat++;
    end
    in_valid = 1'b0;
    if (!o_ov) chk("out_valid_timeout", 128'(o_ov), 128'(1));
    dout = o_dout;
  endtask

  task automatic run(input int s, input bit dec, input logic [127:0] din, input bit toggle,
                     output logic [127:0] dout, output int lat, output int acc_cyc);
    accept(s, dec, din, acc_cyc);
    wait_out(toggle, lat, dout);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    $display("[%0t] NR=%0d dec=%0d in=%h out=%h lat=%0d", $time, s, dec, din, dout, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [127:0] dout, d0, junk, din, expv;
    int lat, acc, prev_acc, min_gap;
    bit dec, seen;

    rst = 1'b1; in_valid = 1'b0; decrypt = 1'b0; out_ready = 1'b0; data_in = '0; sel = 10;
    build_sbox();
    rk10 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10);
    rk12 = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 12);
    rk14 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 14);

    #12;
    chk("rst_in_ready", 128'(o_rdy), 128'(1));
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_out_valid", 128'(o_ov), 128'(0));
    chk("rst_data_out", o_dout, 128'h0);

    @(posedge clk); #1;
    rst = 1'b0;
    // First accept lands on the first edge after reset release.
    accept(10, 1'b0, PT, acc);
    chk("first_accept_busy", 128'(o_busy), 128'(1));
    wait_out(1'b0, lat, dout);
    chk("enc128_data", dout, CT128);
    chk("enc128_latency", 128'(lat), 128'(10));
    out_ready = 1'b1; step(); out_ready = 1'b0;
    $display("[%0t] NR=10 dec=0 in=%h out=%h lat=%0d", $time, PT, dout, lat);

    run(14, 1'b1, CT256, 1'b0, dout, lat, acc);
    chk("dec256_data", dout, PT);
    chk("dec256_latency", 128'(lat), 128'(14));

    run(12, 1'b0, PT, 1'b0, dout, lat, acc);
    chk("enc192_data", dout, CT192);
    chk("enc192_latency", 128'(lat), 128'(12));

    run(10, 1'b0, PT, 1'b1, dout, lat, acc);
    chk("toggle_enc128_data", dout, CT128);

    // Backpressure: result held, nothing accepted while DONE.
    accept(10, 1'b1, CT128, acc);
    wait_out(1'b0, lat, d0);
    chk("bp_dec128_data", d0, PT);
    junk = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    in_valid = 1'b1; decrypt = 1'b0; data_in = junk;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_hold_dout_%0d", i), o_dout, d0);
      chk($sformatf("bp_hold_ready_%0d", i), {126'h0, o_rdy, o_ov}, 128'h1);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("bp_take_idle", {126'h0, o_busy, o_rdy}, 128'h1);
    step();
    chk("bp_accept_next", 128'(o_busy), 128'(1));
    in_valid = 1'b0;
    wait_out(1'b0, lat, dout);
    chk("bp_next_data", dout, m_enc(junk, rk10, 10));
    out_ready = 1'b1; step(); out_ready = 1'b0;
    $display("[%0t] NR=10 dec=0 in=%h out=%h lat=%0d", $time, junk, dout, lat);

    // Asynchronous reset in the middle of round 5.
    accept(10, 1'b0, PT, acc);
    for (int i = 0; i < 4; i++) step();
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", 128'(o_ov), 128'(0));
    chk("arst_in_ready", 128'(o_rdy), 128'(1));
    chk("arst_busy", 128'(o_busy), 128'(0));
    chk("arst_data_out", o_dout, 128'h0);
    #6 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (o_ov) seen = 1'b1;
      step();
    end
    chk("arst_no_out_valid", 128'(seen), 128'(0));
    run(10, 1'b0, PT, 1'b0, dout, lat, acc);
    chk("arst_recover_data", dout, CT128);

    // Back-to-back random traffic on the NR=12 core.
    prev_acc = -1000;
    min_gap  = 1000;
    for (int n = 0; n < 100; n++) begin
      dec  = 1'($urandom_range(0, 1));
      din  = {$urandom, $urandom, $urandom, $urandom};
      expv = dec ? m_dec(din, rk12, 12) : m_enc(din, rk12, 12);
      run(12, dec, din, 1'b0, dout, lat, acc);
      chk($sformatf("rand192_%0d", n), dout, expv);
      if (n > 0 && acc - prev_acc < min_gap) min_gap = acc - prev_acc;
      prev_acc = acc;
    end
    chk("rand192_accept_gap", 128'(min_gap >= 13), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
